// File: rtl/apb4_arb2_if.sv
// APB4 bus between the two-requester arbiter (master) and a single slave.
// Widths follow the arbiter's ADDR_WIDTH/DATA_WIDTH parameters.
interface apb4_arb2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_arb2.sv
// Round-robin arbiter for two requesters onto one APB4 master; ack 3 cycles after grant at best.
// Slave stalls via pready (bounded by TIMEOUT_CYC); requesters hold req_i until their ack pulse.
module apb4_arb2 #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]                 ack_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       err_o,
  apb4_arb2_if.master                apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t     state;
  logic       gnt;
  logic       last_gnt;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_nxt;
  logic       tmo_hit;
  logic       gnt_sel;

  // Under contention the requester not served last wins; a lone request always wins.
  always_comb begin
    gnt_sel = req_i[1];
    if (req_i[0] && req_i[1]) begin
      gnt_sel = ~last_gnt;
    end
  end

  assign tmo_nxt   = tmo_cnt + 8'd1;
  assign tmo_hit   = !apb.pready && (tmo_nxt == 8'(TIMEOUT_CYC));
  assign apb.pprot = 3'b000;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      tmo_cnt     <= 8'd0;
      ack_o       <= 2'b00;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      apb.paddr   <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.pwdata  <= '0;
      apb.pstrb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            gnt         <= gnt_sel;
            last_gnt    <= gnt_sel;
            apb.paddr   <= addr_i[gnt_sel];
            apb.pwrite  <= we_i[gnt_sel];
            apb.pwdata  <= we_i[gnt_sel] ? wdata_i[gnt_sel] : '0;
            apb.pstrb   <= we_i[gnt_sel] ? '1 : '0;
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
            tmo_cnt     <= 8'd0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          apb.penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (!apb.pready) begin
            tmo_cnt <= tmo_nxt;
          end
          if (apb.pready || tmo_hit) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            ack_o       <= gnt ? 2'b10 : 2'b01;
            // A timed-out transfer reports an error with zeroed data.
            rdata_o     <= (apb.pready && !apb.pwrite) ? apb.prdata : '0;
            err_o       <= apb.pready ? apb.pslverr : 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          ack_o <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
